sub_word_serial: RTL and testbench
==================================

SUB_WORD_SERIAL -- requirements
Module: sub_word_serial

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 in_valid  input  1  word_in/round_in/rot_en valid.
REQ-004 in_ready  output  1  block can accept a word; high only in IDLE.
REQ-005 word_in  input  32  word to substitute, byte 3 = [31:24].
REQ-006 round_in  input  4  round tag, passed through to round_out; also the Rcon index.
REQ-007 rot_en  input  1  1 = key-schedule mode: RotWord before SubWord, Rcon XOR after.
REQ-008 out_valid  output  1  word_out/round_out valid.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 word_out  output  32  forward-S-box-substituted word.
REQ-011 round_out  output  4  round tag captured with the word.

Function
REQ-012 The block SHALL be the forward (encrypt and key-expansion) counterpart of the inverse four-byte substitution, using one shared forward S-box serially over four cycles.
REQ-013 States SHALL be IDLE, SUB, DONE; reset state IDLE.
REQ-014 IDLE: on in_valid and in_ready at an edge, the block SHALL capture word (rotated to {word_in[23:0],word_in[31:24]} when rot_en=1), round_in and rot_en, clear byte counter to 0, and go to SUB.
REQ-015 SUB: each edge SHALL replace byte (3 - counter) with S(byte) and increment the counter, MSB first; after counter 3 it SHALL go to DONE.
REQ-016 On entry to DONE with rot_en captured as 1, the result byte [31:24] SHALL be XORed with Rcon(round).
REQ-017 Rcon SHALL be 01,02,04,08,10,20,40,80,1B,36 for round 1..10, and 00 for round 0 and 11..15.
REQ-018 out_valid SHALL be 1 exactly when state is DONE; it rises on the 4th edge after the accepting edge.
REQ-019 DONE: word_out and round_out SHALL hold stable until out_ready=1 at an edge, then the state SHALL return to IDLE (in_ready high the following cycle).
REQ-020 in_valid SHALL be ignored outside IDLE; no input is buffered.
REQ-021 word_out SHALL show the partially substituted register during SUB; consumers qualify only with out_valid.
REQ-022 Throughput SHALL be one word per 6 cycles with out_ready held high.

Reset
REQ-023 With rst_n=0 at an edge, state SHALL become IDLE, counter 0, word_out 32'h0, round_out 4'h0, out_valid 0, and in_ready 1 from the next cycle, in any state including mid-SUB.
REQ-024 A transaction interrupted by reset SHALL be discarded; no partial result appears.

Structure
REQ-025 The Rcon table, state encodings and the 32-bit word width SHALL live in the shared aes_pkg package.
REQ-026 One sub-module SHALL be instantiated: sub_bytes (combinational 8-bit forward S-box, ports sub_in/sub_out), a single instance.
REQ-027 The rest of the RTL SHALL be a single registered FSM with a datapath; no latches.

Verification
REQ-028 rot_en=0, word_in=32'h53535353, round_in=4 -> out_valid 4 edges after accept, word_out=32'hEDEDEDED, round_out=4.
REQ-029 rot_en=1, word_in=32'h09CF4F3C, round_in=1 (FIPS-197 A.1) -> word_out=32'h8B84EB01.
REQ-030 rot_en=1, word_in=32'h00000000, round_in=0 and round_in=12 -> word_out=32'h63636363 in both cases (Rcon 00).
REQ-031 Backpressure: out_ready low for 3 cycles in DONE -> word_out, round_out and out_valid stable; in_valid pulses during this time are ignored; in_ready=1 one cycle after out_ready.
REQ-032 Reset mid-op: rst_n=0 at the 2nd SUB edge -> out_valid=0, word_out=0, in_ready=1 next cycle; the next word_in=32'h00000000 with rot_en=0 gives 32'h63636363.
REQ-033 Back-to-back: two words with out_ready tied high -> accepts 6 cycles apart and both results correct.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: word width, serial-substitution FSM states and the
// key-schedule round constant lookup.
package aes_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_DONE = 2'd2
  } sub_state_t;

  // Rounds outside 1..10 carry no constant, so key-schedule mode degrades to plain SubWord.
  function automatic logic [7:0] rcon(input logic [3:0] round);
    logic [7:0] r;
    case (round)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1B;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sub_bytes.sv
// Combinational AES forward S-box for one byte.
module sub_bytes (
  input  logic [7:0] sub_in,
  output logic [7:0] sub_out
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign sub_out = SBOX[sub_in];

endmodule

// File: rtl/sub_word.sv
// Serial SubWord / key-schedule word transform: one shared S-box, one byte per
// cycle MSB first, optional RotWord before and Rcon XOR after.
module sub_word_serial
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] word_in,
  input  logic [3:0]        round_in,
  input  logic              rot_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] word_out,
  output logic [3:0]        round_out
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid-side data must hold until then, and nothing is buffered.

  sub_state_t        state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic [3:0]        round_q, round_d;
  logic              rot_q, rot_d;

  logic [1:0] byte_sel;
  logic [7:0] sub_in, sub_out;

  assign byte_sel = 2'd3 - cnt_q;
  assign sub_in   = word_q[{byte_sel, 3'b000} +: 8];

  sub_bytes u_sub_bytes (
    .sub_in  (sub_in),
    .sub_out (sub_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    round_d = round_q;
    rot_d   = rot_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          word_d  = rot_en ? {word_in[23:0], word_in[31:24]} : word_in;
          round_d = round_in;
          rot_d   = rot_en;
          cnt_d   = 2'd0;
          state_d = ST_SUB;
        end
      end
      ST_SUB: begin
        word_d[{byte_sel, 3'b000} +: 8] = sub_out;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // Byte 3 was substituted on the first SUB edge, so the XOR sees S(byte).
          if (rot_q) word_d[31:24] = word_q[31:24] ^ rcon(round_q);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 2'd0;
      word_q  <= '0;
      round_q <= 4'h0;
      rot_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      round_q <= round_d;
      rot_q   <= rot_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign word_out  = word_q;
  assign round_out = round_q;

endmodule

// File: tb/tb_sub_word_serial.sv
// Directed bench for sub_word_serial: hand-computed S-box / key-schedule words,
// latency, backpressure, mid-operation reset and back-to-back throughput.
module tb_sub_word_serial;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] word_in;
  logic [3:0]  round_in;
  logic        rot_en;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] word_out;
  logic [3:0]  round_out;

  int vec_cnt  = 0;
  int miss_cnt = 0;
  logic [31:0] exp_q[$];

  sub_word_serial dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .word_in   (word_in),
    .round_in  (round_in),
    .rot_en    (rot_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .word_out  (word_out),
    .round_out (round_out)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks; every task starts and ends 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [3:0] r, input logic rot);
    int n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) check_eq("accept_wait", {31'd0, in_ready}, 32'd1);
    word_in  = w;
    round_in = r;
    rot_en   = rot;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 20);
  endtask

  task automatic run_one(input string tag, input logic [31:0] w, input logic [3:0] r,
                         input logic rot, input logic [31:0] exp_w);
    int lat;
    send(w, r, rot);
    wait_result(lat);
    check_eq({tag, "_latency"}, lat, 32'd4);
    check_eq({tag, "_word"}, word_out, exp_w);
    check_eq({tag, "_round"}, {28'd0, round_out}, {28'd0, r});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    int lat;
    int cyc;
    int acc_t [2];
    int n_acc;
    int n_res;
    logic acc;

    rst_n = 1'b0; in_valid = 1'b0; word_in = '0; round_in = '0; rot_en = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_word_out", word_out, 32'h0);
    check_eq("rst_round_out", {28'd0, round_out}, 32'd0);
    rst_n = 1'b1;
    tick();

    run_one("sub53", 32'h53535353, 4'd4, 1'b0, 32'hEDEDEDED);
    run_one("fips_a1", 32'h09CF4F3C, 4'd1, 1'b1, 32'h8B84EB01);
    run_one("rcon_r0", 32'h00000000, 4'd0, 1'b1, 32'h63636363);
    run_one("rcon_r12", 32'h00000000, 4'd12, 1'b1, 32'h63636363);
    run_one("rcon_r9", 32'h00000000, 4'd9, 1'b1, 32'h78636363);
    run_one("rcon_r10", 32'h00000000, 4'd10, 1'b1, 32'h55636363);

    // Backpressure with stray in_valid pulses while the result is held
    send(32'h53535353, 4'd4, 1'b0);
    wait_result(lat);
    check_eq("bp_latency", lat, 32'd4);
    for (int i = 0; i < 3; i++) begin
      word_in = 32'hDEADBEEF; round_in = 4'd7; rot_en = 1'b1; in_valid = (i != 1);
      tick();
      check_eq("bp_word_hold", word_out, 32'hEDEDEDED);
      check_eq("bp_round_hold", {28'd0, round_out}, 32'd4);
      check_eq("bp_valid_hold", {31'd0, out_valid}, 32'd1);
      check_eq("bp_not_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    tick();
    check_eq("bp_no_stray_accept", {31'd0, in_ready}, 32'd1);

    // Reset asserted at the second SUB edge
    send(32'h09CF4F3C, 4'd1, 1'b1);
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_word_out", word_out, 32'h0);
    check_eq("mid_rst_round_out", {28'd0, round_out}, 32'd0);
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check_eq("mid_rst_discarded", {31'd0, out_valid}, 32'd0);
    run_one("post_rst", 32'h00000000, 4'd0, 1'b0, 32'h63636363);

    // Back-to-back with out_ready tied high
    exp_q.push_back(32'hEDEDEDED);
    exp_q.push_back(32'h8B84EB01);
    out_ready = 1'b1;
    word_in = 32'h53535353; round_in = 4'd4; rot_en = 1'b0; in_valid = 1'b1;
    cyc = 0; n_acc = 0; n_res = 0;
    while (n_res < 2 && cyc < 40) begin
      acc = in_ready && in_valid;
      if (out_valid) begin
        check_eq("b2b_word", word_out, exp_q.pop_front());
        n_res++;
      end
      tick();
      cyc++;
      if (acc && n_acc < 2) begin
        acc_t[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          word_in = 32'h09CF4F3C; round_in = 4'd1; rot_en = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_eq("b2b_results_seen", n_res, 32'd2);
    check_eq("b2b_accepts", n_acc, 32'd2);
    if (n_acc == 2) check_eq("b2b_accept_gap", acc_t[1] - acc_t[0], 32'd6);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
